// File: rtl/comp_pkg.sv
// Shared types for the serial magnitude comparator: FSM state encoding and the
// one-hot EQ/GT/LT result bundle.
package comp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } result_t;

    localparam result_t RES_NONE = 3'b000;
    localparam result_t RES_EQ   = 3'b100;
    localparam result_t RES_GT   = 3'b010;
    localparam result_t RES_LT   = 3'b001;

    // Index register must stay at least one bit wide even for a single slice.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/comp_slice.sv
// Unsigned magnitude compare of one DIGIT-bit slice; purely combinational.
module comp_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    output logic             gt_o,
    output logic             lt_o
);

    assign gt_o = (a_i > b_i);
    assign lt_o = (a_i < b_i);

endmodule

// File: rtl/comp_serial.sv
// Digit-serial A/B comparator: walks DIGIT-bit slices MSB-first, stops at the
// first differing slice, and reports a sticky one-hot EQ/GT/LT result.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; previous result held on EQ/GT/LT
//   RUN   | comparing slice idx_q of the captured (shifted) operands
//   DONE  | result valid, done pulses for this single cycle
module comp_serial
    import comp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             EQ,
    output logic             GT,
    output logic             LT
);

    localparam int DIG      = (DIGIT < 1) ? 1 : DIGIT;
    localparam int N        = WIDTH / DIG;
    localparam int IDXW     = idx_width(N);
    localparam int IDX_LAST = (N > 0) ? N - 1 : 0;

    generate
        if ((DIGIT < 1) || ((WIDTH % DIG) != 0) || (N < 1)) begin : g_bad_cfg
            $error("comp_serial: WIDTH must be a nonzero multiple of DIGIT, DIGIT >= 1");
        end
    endgenerate

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              sgn_q, sgn_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    result_t           res_q, res_d;

    logic [DIG-1:0]    slice_a;
    logic [DIG-1:0]    slice_b;
    logic              slice_gt;
    logic              slice_lt;

    // Flipping the sign bit of the top slice maps two's complement onto
    // offset binary, so the unsigned slice compare serves both modes.
    always_comb begin
        slice_a = a_q[WIDTH-1 -: DIG];
        slice_b = b_q[WIDTH-1 -: DIG];
        if (sgn_q && (idx_q == '0)) begin
            slice_a[DIG-1] = ~slice_a[DIG-1];
            slice_b[DIG-1] = ~slice_b[DIG-1];
        end
    end

    comp_slice #(
        .DIGIT (DIG)
    ) u_slice (
        .a_i  (slice_a),
        .b_i  (slice_b),
        .gt_o (slice_gt),
        .lt_o (slice_lt)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        idx_d   = idx_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    sgn_d   = signed_mode;
                    idx_d   = '0;
                    res_d   = RES_NONE;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (slice_gt) begin
                    res_d   = RES_GT;
                    state_d = DONE;
                end else if (slice_lt) begin
                    res_d   = RES_LT;
                    state_d = DONE;
                end else if (idx_q == IDXW'(IDX_LAST)) begin
                    res_d   = RES_EQ;
                    state_d = DONE;
                end else begin
                    a_d   = a_q << DIG;
                    b_d   = b_q << DIG;
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            idx_q   <= '0;
            res_q   <= RES_NONE;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign EQ   = res_q.eq;
    assign GT   = res_q.gt;
    assign LT   = res_q.lt;

endmodule

// File: tb/tb_comp_serial.sv
// Scoreboard bench for comp_serial: a 16/4 instance and a 4/1 instance checked
// against an integer-compare reference model with slice-based latency.
module tb_comp_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start16 = 1'b0, sgn16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, eq16, gt16, lt16;
    logic        start4 = 1'b0, sgn4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        busy4, done4, eq4, gt4, lt4;

    comp_serial #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sgn16),
        .A(a16), .B(b16), .busy(busy16), .done(done16),
        .EQ(eq16), .GT(gt16), .LT(lt16)
    );

    comp_serial #(.WIDTH(4), .DIGIT(1)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(sgn4),
        .A(a4), .B(b4), .busy(busy4), .done(done4),
        .EQ(eq4), .GT(gt4), .LT(lt4)
    );

    typedef struct {
        bit eq;
        bit gt;
        bit lt;
        int done_cyc;
    } exp_t;

    exp_t q16[$];
    exp_t q4[$];
    int   cyc = 0;
    int   ntests = 0;
    int   nfail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string what);
        ntests++;
        nfail++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // Reference: plain integer compare for the result; latency from the first
    // differing DIGIT-wide chunk counted from the MSB end.
    function automatic exp_t model(input int unsigned a, input int unsigned b, input bit sgn,
                                   input int w, input int d, input int start_cyc);
        exp_t        e;
        longint      sa, sb;
        int          n, lat;
        int unsigned ma, mb;
        sa = longint'(a);
        sb = longint'(b);
        if (sgn) begin
            if (a >= (32'd1 << (w - 1))) sa = sa - (longint'(1) << w);
            if (b >= (32'd1 << (w - 1))) sb = sb - (longint'(1) << w);
        end
        e.eq = (sa == sb);
        e.gt = (sa > sb);
        e.lt = (sa < sb);
        n    = w / d;
        lat  = n + 1;
        for (int i = 0; i < n; i++) begin
            ma = (a >> (w - d * (i + 1))) & ((32'd1 << d) - 1);
            mb = (b >> (w - d * (i + 1))) & ((32'd1 << d) - 1);
            if (ma != mb) begin
                lat = 2 + i;
                break;
            end
        end
        e.done_cyc = start_cyc + lat;
        return e;
    endfunction

    // Called #1 after a rising edge; returns the same way, one edge later.
    task automatic issue(input bit w4, input logic [15:0] a, input logic [15:0] b,
                         input bit sgn, output int sc);
        int t;
        t = 0;
        while (((w4 ? busy4 : busy16) !== 1'b0) && (t < 40)) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 40) fail("wait_idle", "busy never dropped");
        sc = cyc;
        if (w4) begin
            a4 = a[3:0]; b4 = b[3:0]; sgn4 = sgn; start4 = 1'b1;
            q4.push_back(model(32'(a[3:0]), 32'(b[3:0]), sgn, 4, 1, cyc));
        end else begin
            a16 = a; b16 = b; sgn16 = sgn; start16 = 1'b1;
            q16.push_back(model(32'(a), 32'(b), sgn, 16, 4, cyc));
        end
        @(posedge clk); #1;
        start4  = 1'b0;
        start16 = 1'b0;
        a16  = 16'($urandom);
        b16  = 16'($urandom);
        sgn16 = 1'($urandom);
        a4   = 4'($urandom);
        b4   = 4'($urandom);
        sgn4 = 1'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q16.size() != 0 || q4.size() != 0 || busy16 !== 1'b0 || busy4 !== 1'b0)
               && (t < 100)) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) fail("drain", "pending results never completed");
    endtask

    initial begin : mon16
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (done16 === 1'b1) begin
                if (q16.size() == 0) begin
                    fail("unexp_done16", "done with no outstanding request");
                end else begin
                    e = q16.pop_front();
                    check("res16", {29'd0, eq16, gt16, lt16}, {29'd0, e.eq, e.gt, e.lt});
                    check("lat16", cyc, e.done_cyc);
                    check("busy_at_done16", {31'd0, busy16}, 32'd1);
                end
            end
        end
    end

    initial begin : mon4
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (done4 === 1'b1) begin
                if (q4.size() == 0) begin
                    fail("unexp_done4", "done with no outstanding request");
                end else begin
                    e = q4.pop_front();
                    check("res4", {29'd0, eq4, gt4, lt4}, {29'd0, e.eq, e.gt, e.lt});
                    check("lat4", cyc, e.done_cyc);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int   s;
        exp_t dropped;
        logic [15:0] ra, rb;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out16", {27'd0, busy16, done16, eq16, gt16, lt16}, 32'd0);
        check("rst_out4",  {27'd0, busy4, done4, eq4, gt4, lt4}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        issue(0, 16'h1234, 16'h1234, 1'b0, s);
        drain();
        issue(0, 16'h9000, 16'h1000, 1'b0, s);
        drain();
        issue(0, 16'h9000, 16'h1000, 1'b1, s);
        drain();

        issue(0, 16'h00A5, 16'h00A6, 1'b0, s);
        drain();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_res", {29'd0, eq16, gt16, lt16}, 32'b001);
        end

        // start pulses in RUN and DONE must be ignored
        issue(0, 16'h00A5, 16'h00A6, 1'b0, s);
        start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0000;
        @(posedge clk); #1;
        start16 = 1'b0;
        while (cyc < s + 5) begin
            @(posedge clk); #1;
        end
        check("done_cycle_seen", {31'd0, done16}, 32'd1);
        start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0000;
        @(posedge clk); #1;
        start16 = 1'b0;
        check("start_in_done_ignored", {31'd0, busy16}, 32'd0);
        check("res_after_ignore", {29'd0, eq16, gt16, lt16}, 32'b001);

        // reset mid-RUN aborts with no done pulse
        issue(0, 16'h00A5, 16'h00A6, 1'b0, s);
        @(posedge clk); #1;
        rst = 1'b1;
        dropped = q16.pop_back();
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_midrun", {27'd0, busy16, done16, eq16, gt16, lt16}, 32'd0);
        repeat (8) begin
            @(posedge clk); #1;
        end
        check("idle_after_abort", {31'd0, busy16}, 32'd0);
        issue(0, 16'h8000, 16'h7FFF, 1'b1, s);
        drain();

        // randomized 16-bit traffic, biased toward long equal prefixes
        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (16'd1 << $urandom_range(0, 15));
                default: rb = 16'($urandom);
            endcase
            issue(0, ra, rb, 1'($urandom), s);
        end
        drain();

        // exhaustive 4-bit, 1-bit digits, back-to-back
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    issue(1, 16'(a), 16'(b), 1'(m), s);
                end
            end
        end
        drain();

        check("q16_empty", q16.size(), 32'd0);
        check("q4_empty", q4.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/comp_serial.md
COMP_SERIAL -- requirements
Module: comp_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, which sets the operand width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4, which sets the bits compared per cycle; N = WIDTH/DIGIT slices.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: a request to begin a comparison.
REQ-006 The block SHALL have port signed_mode, input, 1 bit: 1 = two's-complement compare, 0 = unsigned compare.
REQ-007 The block SHALL have port A, input, WIDTH bits: operand A.
REQ-008 The block SHALL have port B, input, WIDTH bits: operand B.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a comparison is in progress and not yet acknowledged.
REQ-010 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking a valid result.
REQ-011 The block SHALL have ports EQ, GT, LT, output, 1 bit each: A==B, A>B and A<B results.

Function
REQ-012 States SHALL be IDLE, RUN and DONE; busy = (state != IDLE); done = (state == DONE).
REQ-013 In IDLE with start=1, the block SHALL capture A, B and signed_mode into internal registers, clear EQ/GT/LT, reset the slice index to 0 and enter RUN.
REQ-014 In RUN, the block SHALL compare the current most-significant unprocessed DIGIT-bit slice of the captured operands, going MSB-first.
REQ-015 In signed mode, the top bit of slice 0 of both captured operands SHALL be inverted before comparison (offset-binary equivalence); other slices are unmodified.
REQ-016 On the first differing slice, the block SHALL set GT or LT and enter DONE (early termination); remaining slices are not examined.
REQ-017 If slice N-1 is equal, the block SHALL set EQ and enter DONE; otherwise it SHALL shift the captured operands left by DIGIT and increment the index.
REQ-018 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-019 EQ/GT/LT SHALL hold their values after DONE until the next accepted start.
REQ-020 After a decision, exactly one of EQ/GT/LT SHALL be 1.
REQ-021 Latency: with start sampled in cycle 0 and the first differing slice k (0-based), done SHALL be high in cycle 2+k; for equal operands done SHALL be high in cycle N+1.
REQ-022 start SHALL be ignored while busy=1, including in the DONE cycle; A/B changes during RUN SHALL have no effect.
REQ-023 start SHALL be accepted in the first IDLE cycle following DONE.
REQ-024 WIDTH % DIGIT != 0 or DIGIT < 1 SHALL produce an elaboration-time error.
REQ-025 The slice index width SHALL be max(1, $clog2(N)).
REQ-026 N = 1 SHALL be legal: a single RUN cycle, with done in cycle 2.

Reset
REQ-027 While rst=1 at a clock edge, state SHALL become IDLE and busy, done, EQ, GT, LT SHALL be 0.
REQ-028 Reset SHALL take priority over start.
REQ-029 Reset during RUN or DONE SHALL abort the comparison with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Structure
REQ-030 Package comp_pkg SHALL hold the state enum typedef (IDLE, RUN, DONE) and a result typedef {eq, gt, lt}.
REQ-031 A combinational sub-module comp_slice, parametrised by DIGIT and producing gt/lt for one slice, SHALL be instantiated once.
REQ-032 All outputs SHALL be registered or decoded from the state register only.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-033 The bench SHALL drive unsigned A=16'h1234, B=16'h1234 and require done only in cycle 5, with EQ=1, GT=0, LT=0.
REQ-034 The bench SHALL drive A=16'h9000, B=16'h1000, requiring done in cycle 2 with GT=1 when unsigned and LT=1 when signed.
REQ-035 The bench SHALL drive unsigned A=16'h00A5, B=16'h00A6 and require done in cycle 5 with LT=1, then results held 10 idle cycles.
REQ-036 The bench SHALL pulse start in the RUN and DONE cycles and require both to be ignored, then assert rst mid-RUN and require all outputs 0, no done pulse, and the next start to complete correctly.
REQ-037 The bench SHALL run WIDTH=4, DIGIT=1 over all 256 pairs in both modes, back-to-back starts, and require results to match a behavioural model with zero mismatches.
